// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback ports, scoreboard reserve/check and the registered regfile write port.
// The arbiter sits on the slave side. The issue/writeback logic (or a bench) sits on the master side.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Handshake: a write on a port happens in a cycle where both valid and ready are high.
  // Ready is combinational. It is driven by arbitration only, never by how long valid has been held.
  // Valid may drop without a transfer.
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_reg;
  logic              a_float;
  logic [DATA_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_reg;
  logic              b_float;
  logic [DATA_W-1:0] b_data;

  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_reg;
  logic              rsv_float;

  logic [ADDR_W-1:0] chk_reg1;
  logic [ADDR_W-1:0] chk_reg2;
  logic              chk_float;
  logic              hazard;

  logic              rf_regWrite;
  logic              rf_float;
  logic [ADDR_W-1:0] rf_writeReg;
  logic [DATA_W-1:0] rf_writeData;

  logic              last_grant_dbg;

  modport master (
    output a_valid, a_reg, a_float, a_data,
    output b_valid, b_reg, b_float, b_data,
    output rsv_valid, rsv_reg, rsv_float,
    output chk_reg1, chk_reg2, chk_float,
    input  a_ready, b_ready, hazard,
    input  rf_regWrite, rf_float, rf_writeReg, rf_writeData,
    input  last_grant_dbg
  );

  modport slave (
    input  a_valid, a_reg, a_float, a_data,
    input  b_valid, b_reg, b_float, b_data,
    input  rsv_valid, rsv_reg, rsv_float,
    input  chk_reg1, chk_reg2, chk_float,
    output a_ready, b_ready, hazard,
    output rf_regWrite, rf_float, rf_writeReg, rf_writeData,
    output last_grant_dbg
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the regfile write port between the ALU/load path (A) and the FPU (B).
// It also keeps a per-bank destination scoreboard so that issue can detect RAW hazards.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} grant_e;

  grant_e            last_q, last_d;
  logic              grant_a, grant_b;
  logic              a_xfer, b_xfer, xfer;
  logic              sel_float;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic              rf_we_q, rf_we_d;
  logic              rf_float_q, rf_float_d;
  logic [ADDR_W-1:0] rf_reg_q, rf_reg_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic [NREG-1:0]   pend_i_q, pend_i_d;
  logic [NREG-1:0]   pend_f_q, pend_f_d;
  logic [NREG-1:0]   chk_bank;
  logic              haz1, haz2;

  // Round-robin state register
  always_ff @(posedge clk) begin
    if (rst) last_q <= LAST_B;
    else     last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (a_xfer)      last_d = LAST_A;
    else if (b_xfer) last_d = LAST_B;
  end

  // On contention the grant goes to the port that did not win last time.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_a = (last_q == LAST_B);
        grant_b = (last_q == LAST_A);
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  assign bus.a_ready        = grant_a;
  assign bus.b_ready        = grant_b;
  assign bus.last_grant_dbg = last_q;
  assign a_xfer             = bus.a_valid & grant_a;
  assign b_xfer             = bus.b_valid & grant_b;
  assign xfer               = a_xfer | b_xfer;

  always_comb begin
    sel_float = bus.b_float;
    sel_reg   = bus.b_reg;
    sel_data  = bus.b_data;
    if (grant_a) begin
      sel_float = bus.a_float;
      sel_reg   = bus.a_reg;
      sel_data  = bus.a_data;
    end
  end

  // A write to register 0 is accepted but produces no regfile write. The address and data fields keep their old values.
  always_comb begin
    rf_we_d    = xfer && (sel_reg != '0);
    rf_float_d = rf_float_q;
    rf_reg_d   = rf_reg_q;
    rf_data_d  = rf_data_q;
    if (rf_we_d) begin
      rf_float_d = sel_float;
      rf_reg_d   = sel_reg;
      rf_data_d  = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_float_q <= 1'b0;
      rf_reg_q   <= '0;
      rf_data_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_float_q <= rf_float_d;
      rf_reg_q   <= rf_reg_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign bus.rf_regWrite  = rf_we_q;
  assign bus.rf_float     = rf_float_q;
  assign bus.rf_writeReg  = rf_reg_q;
  assign bus.rf_writeData = rf_data_q;

  // Pending bits are cleared first and set second, so a reservation in the same cycle as a transfer to that register wins.
  always_comb begin
    pend_i_d = pend_i_q;
    pend_f_d = pend_f_q;
    if (xfer && (sel_reg != '0)) begin
      if (sel_float) pend_f_d[sel_reg] = 1'b0;
      else           pend_i_d[sel_reg] = 1'b0;
    end
    if (bus.rsv_valid && (bus.rsv_reg != '0)) begin
      if (bus.rsv_float) pend_f_d[bus.rsv_reg] = 1'b1;
      else               pend_i_d[bus.rsv_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_i_q <= '0;
      pend_f_q <= '0;
    end else begin
      pend_i_q <= pend_i_d;
      pend_f_q <= pend_f_d;
    end
  end

  // A write sitting in rf_* has already cleared its pending bit but has not reached the regfile, so it still counts as a hazard.
  assign chk_bank = bus.chk_float ? pend_f_q : pend_i_q;
  assign haz1 = (bus.chk_reg1 != '0) &&
                (chk_bank[bus.chk_reg1] ||
                 (rf_we_q && (rf_float_q == bus.chk_float) && (rf_reg_q == bus.chk_reg1)));
  assign haz2 = (bus.chk_reg2 != '0) &&
                (chk_bank[bus.chk_reg2] ||
                 (rf_we_q && (rf_float_q == bus.chk_float) && (rf_reg_q == bus.chk_reg2)));
  assign bus.hazard = haz1 | haz2;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random bench for regfile_wb_arbiter. A reference round-robin model predicts each grant,
// and the expected regfile write is queued until the cycle in which it appears on rf_*.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int EW     = 2 + ADDR_W + DATA_W;

  logic clk = 1'b0;
  logic rst;

  // clock / reset
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [EW-1:0] exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic model_last_b = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predict the grant for the current inputs, compare it with the readies, and queue the resulting regfile write.
  task automatic settle();
    logic          ga, gb;
    logic [EW-1:0] e;
    #1;
    ga = 1'b0;
    gb = 1'b0;
    if (!rst) begin
      if (bus.a_valid && bus.b_valid) begin
        ga = model_last_b;
        gb = !model_last_b;
      end else begin
        ga = bus.a_valid;
        gb = bus.b_valid;
      end
    end
    check("a_ready", 64'(bus.a_ready), 64'(ga));
    check("b_ready", 64'(bus.b_ready), 64'(gb));
    e = '0;
    if (ga) begin
      e = {(bus.a_reg != '0), bus.a_float, bus.a_reg, bus.a_data};
      model_last_b = 1'b0;
    end else if (gb) begin
      e = {(bus.b_reg != '0), bus.b_float, bus.b_reg, bus.b_data};
      model_last_b = 1'b1;
    end
    if (rst) model_last_b = 1'b1;
    exp_q.push_back(e);
  endtask

  // Wait for the active edge, then compare rf_* against the oldest queued expectation.
  task automatic edge_chk();
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_underrun", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("rf_regWrite", 64'(bus.rf_regWrite), 64'(e[EW-1]));
      if (e[EW-1]) begin
        check("rf_float", 64'(bus.rf_float), 64'(e[EW-2]));
        check("rf_writeReg", 64'(bus.rf_writeReg), 64'(e[DATA_W+ADDR_W-1:DATA_W]));
        check("rf_writeData", 64'(bus.rf_writeData), 64'(e[DATA_W-1:0]));
      end
    end
  endtask

  task automatic cyc();
    settle();
    edge_chk();
  endtask

  task automatic haz(input string tag, input logic exp_h);
    #1;
    check(tag, 64'(bus.hazard), 64'(exp_h));
  endtask

  task automatic idle_inputs();
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b0;
    bus.rsv_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.a_valid   = 1'b1; bus.a_reg = 5'd3; bus.a_float = 1'b0; bus.a_data = 32'h1111_1111;
    bus.b_valid   = 1'b1; bus.b_reg = 5'd4; bus.b_float = 1'b1; bus.b_data = 32'h2222_2222;
    bus.rsv_valid = 1'b0; bus.rsv_reg = '0; bus.rsv_float = 1'b0;
    bus.chk_reg1  = '0;   bus.chk_reg2 = '0; bus.chk_float = 1'b0;

    // Reset held for two cycles while both ports request
    cyc();
    for (int i = 0; i < 32; i++) begin
      bus.chk_float = i[0];
      bus.chk_reg1  = 5'(i);
      bus.chk_reg2  = 5'(31 - i);
      haz("reset_hazard", 1'b0);
    end
    cyc();
    rst = 1'b0;
    idle_inputs();
    cyc();

    // Single write from A
    bus.a_valid = 1'b1; bus.a_reg = 5'd5; bus.a_float = 1'b0; bus.a_data = 32'hDEAD_BEEF;
    settle();
    edge_chk();
    idle_inputs();
    cyc();

    // Contention immediately after reset: the grants should alternate A, B, A, B
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.a_valid = 1'b1; bus.a_reg = 5'($urandom_range(1, 31)); bus.a_float = 1'($urandom_range(0, 1));
      bus.a_data  = $urandom;
      bus.b_valid = 1'b1; bus.b_reg = 5'($urandom_range(1, 31)); bus.b_float = 1'($urandom_range(0, 1));
      bus.b_data  = $urandom;
      settle();
      check("rr_grant_a", 64'(bus.a_ready), 64'(i % 2 == 0));
      edge_chk();
    end
    idle_inputs();
    cyc();

    // Scoreboard: reserve f7, then B retires it
    bus.rsv_valid = 1'b1; bus.rsv_reg = 5'd7; bus.rsv_float = 1'b1;
    cyc();
    bus.rsv_valid = 1'b0;
    bus.chk_float = 1'b1; bus.chk_reg1 = 5'd7; bus.chk_reg2 = 5'd0;
    settle();
    haz("f7_pending_src1", 1'b1);
    bus.chk_reg1 = 5'd0; bus.chk_reg2 = 5'd7;
    haz("f7_pending_src2", 1'b1);
    edge_chk();
    bus.chk_reg1 = 5'd7; bus.chk_reg2 = 5'd0;
    bus.b_valid = 1'b1; bus.b_reg = 5'd7; bus.b_float = 1'b1; bus.b_data = 32'hCAFE_F00D;
    settle();
    haz("f7_before_xfer", 1'b1);
    edge_chk();
    idle_inputs();
    settle();
    haz("f7_in_flight", 1'b1);
    edge_chk();
    settle();
    haz("f7_committed", 1'b0);
    bus.chk_float = 1'b0;
    haz("r7_int_clear", 1'b0);
    edge_chk();

    // Register 0 is accepted with no write, and the round-robin pointer still advances
    bus.a_valid = 1'b1; bus.a_reg = 5'd0; bus.a_float = 1'b0; bus.a_data = 32'h0BAD_0BAD;
    cyc();
    bus.a_reg = 5'd12; bus.b_valid = 1'b1; bus.b_reg = 5'd13; bus.b_float = 1'b0; bus.b_data = 32'h1313_1313;
    settle();
    check("rr_after_r0", 64'(bus.b_ready), 64'd1);
    edge_chk();
    idle_inputs();
    bus.rsv_valid = 1'b1; bus.rsv_reg = 5'd0; bus.rsv_float = 1'b0;
    cyc();
    bus.rsv_valid = 1'b0;
    bus.chk_float = 1'b0; bus.chk_reg1 = 5'd0; bus.chk_reg2 = 5'd0;
    settle();
    haz("r0_no_hazard", 1'b0);
    edge_chk();

    // Reservation and retirement of r9 in the same cycle: the reservation must win
    bus.rsv_valid = 1'b1; bus.rsv_reg = 5'd9; bus.rsv_float = 1'b0;
    bus.b_valid = 1'b1; bus.b_reg = 5'd9; bus.b_float = 1'b0; bus.b_data = 32'h9999_0009;
    cyc();
    idle_inputs();
    bus.chk_float = 1'b0; bus.chk_reg1 = 5'd9;
    cyc();
    settle();
    haz("r9_set_wins", 1'b1);
    edge_chk();
    bus.a_valid = 1'b1; bus.a_reg = 5'd9; bus.a_float = 1'b0; bus.a_data = 32'h9999_1111;
    cyc();
    idle_inputs();
    settle();
    haz("r9_in_flight", 1'b1);
    edge_chk();
    settle();
    haz("r9_retired", 1'b0);
    edge_chk();

    // Random traffic on both ports, checked against the reference model and the queue
    for (int i = 0; i < 40; i++) begin
      bus.a_valid = 1'($urandom_range(0, 1)); bus.a_reg = 5'($urandom_range(0, 31));
      bus.a_float = 1'($urandom_range(0, 1)); bus.a_data = $urandom;
      bus.b_valid = 1'($urandom_range(0, 1)); bus.b_reg = 5'($urandom_range(0, 31));
      bus.b_float = 1'($urandom_range(0, 1)); bus.b_data = $urandom;
      cyc();
    end
    idle_inputs();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
